// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_monitor
// Purpose  : Passive I2C frame decoder (sync, glitch filter, START/STOP, bytes)
// Revision : 1.0  initial release
// ============================================================================
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_raw,
    input  logic       sda_raw,
    output logic       bus_busy,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic [1:0] phase,
    output logic [3:0] bit_idx,
    output logic       addr_valid,
    output logic [6:0] addr,
    output logic       rw,
    output logic       data_valid,
    output logic [7:0] data,
    output logic       ack_valid,
    output logic       ack_n
);

    localparam int unsigned c_CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_ACK  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {sda_raw, scl_raw};

    // Index 0 is SCL, index 1 is SDA; both lines share the same latency so
    // their relative ordering is preserved through the filter.
    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_f;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '1;
                r_cnt  <= '0;
                r_f    <= 1'b1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[SYNC_STAGES-1] == r_f) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_f   <= r_sync[SYNC_STAGES-1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[i] = r_f;
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    state_t     r_state;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       r_got_rise;
    logic [7:0] r_shift;
    logic [3:0] r_bit_idx;
    logic       r_busy;
    logic       r_start_pulse;
    logic       r_stop_pulse;
    logic       r_addr_valid;
    logic [6:0] r_addr;
    logic       r_rw;
    logic       r_data_valid;
    logic [7:0] r_data;
    logic       r_ack_valid;
    logic       r_ack_n;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    assign w_sda_rise =  w_sda & ~r_sda_prev;
    assign w_sda_fall = ~w_sda &  r_sda_prev;
    // SCL stable high across both cycles also rules out a coincident SCL edge.
    assign w_start    = w_sda_fall & w_scl & r_scl_prev;
    assign w_stop     = w_sda_rise & w_scl & r_scl_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_scl_prev    <= 1'b1;
            r_sda_prev    <= 1'b1;
            r_got_rise    <= 1'b0;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_busy        <= 1'b0;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_addr        <= '0;
            r_rw          <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data        <= '0;
            r_ack_valid   <= 1'b0;
            r_ack_n       <= 1'b0;
        end else begin
            r_scl_prev    <= w_scl;
            r_sda_prev    <= w_sda;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_data_valid  <= 1'b0;
            r_ack_valid   <= 1'b0;

            if (w_start) begin
                r_state       <= S_ADDR;
                r_busy        <= 1'b1;
                r_start_pulse <= 1'b1;
                r_bit_idx     <= '0;
                r_shift       <= '0;
                r_got_rise    <= 1'b0;
            end else if (w_stop) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_stop_pulse <= 1'b1;
                r_bit_idx    <= '0;
                r_got_rise   <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_scl_rise) begin
                    r_got_rise <= 1'b1;
                    case (r_state)
                        S_ADDR: begin
                            r_shift <= {r_shift[6:0], w_sda};
                            if (r_bit_idx == 4'd7) begin
                                r_addr       <= r_shift[6:0];
                                r_rw         <= w_sda;
                                r_addr_valid <= 1'b1;
                            end
                        end
                        S_DATA: begin
                            r_shift <= {r_shift[6:0], w_sda};
                            if (r_bit_idx == 4'd7) begin
                                r_data       <= {r_shift[6:0], w_sda};
                                r_data_valid <= 1'b1;
                            end
                        end
                        S_ACK: begin
                            r_ack_n     <= w_sda;
                            r_ack_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                // The SCL fall that closes a START has no bit behind it.
                end else if (w_scl_fall && r_got_rise) begin
                    r_got_rise <= 1'b0;
                    case (r_state)
                        S_ADDR, S_DATA: begin
                            if (r_bit_idx == 4'd7) begin
                                r_state   <= S_ACK;
                                r_bit_idx <= 4'd8;
                            end else begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end
                        S_ACK: begin
                            r_state   <= r_ack_n ? S_IDLE : S_DATA;
                            r_bit_idx <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus_busy    = r_busy;
    assign start_pulse = r_start_pulse;
    assign stop_pulse  = r_stop_pulse;
    assign phase       = r_state;
    assign bit_idx     = r_bit_idx;
    assign addr_valid  = r_addr_valid;
    assign addr        = r_addr;
    assign rw          = r_rw;
    assign data_valid  = r_data_valid;
    assign data        = r_data;
    assign ack_valid   = r_ack_valid;
    assign ack_n       = r_ack_n;

endmodule
`default_nettype wire
